// File: rtl/mod_word_collector2048.sv
// rtl/mod_word_collector2048.sv - packs NWORDS W-bit words (LS word first) into one oW-bit operand
module mod_word_collector2048 #(
  parameter int W      = 32,
  parameter int oW     = 2048,
  parameter int NWORDS = 64,
  parameter int CW     = 7
) (
  input  logic          iClk,
  input  logic          iRst,
  input  logic          iStart,
  input  logic          iValid,
  input  logic [W-1:0]  iData,
  output logic          oReady,
  output logic [CW-1:0] oCount,
  output logic          oValid,
  input  logic          iAck,
  output logic [oW-1:0] oData,
  output logic          oBusy
);

  typedef enum logic [1:0] {IDLE, COLLECT, FULL} state_t;

  state_t        state, stateNext;
  logic [oW-1:0] buffer;
  logic [CW-1:0] count;
  logic          clear;
  logic          accept;

  always_comb begin
    stateNext = state;
    clear     = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (iStart) begin
          clear     = 1'b1;
          stateNext = COLLECT;
        end
      end
      COLLECT: begin
        // An abort wins over a word presented in the same cycle
        if (iStart) begin
          clear = 1'b1;
        end else if (iValid) begin
          accept = 1'b1;
          if (count == CW'(NWORDS - 1)) stateNext = FULL;
        end
      end
      FULL: begin
        if (iStart) begin
          clear     = 1'b1;
          stateNext = COLLECT;
        end else if (iAck) begin
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state  <= IDLE;
      buffer <= '0;
      count  <= '0;
    end else begin
      state <= stateNext;
      if (clear) begin
        buffer <= '0;
        count  <= '0;
      end else if (accept) begin
        // New word enters at the top so word 0 ends up at the bottom
        buffer <= {iData, buffer[oW-1:W]};
        count  <= count + 1'b1;
      end
    end
  end

  assign oReady = (state == COLLECT);
  assign oValid = (state == FULL);
  assign oBusy  = (state == COLLECT) || (state == FULL);
  assign oCount = count;
  assign oData  = buffer;

endmodule

// File: tb/tb_mod_word_collector2048.sv
// tb/tb_mod_word_collector2048.sv - directed bench for mod_word_collector2048
module tb_mod_word_collector2048;

  logic          iClk = 1'b0;
  logic          iRst = 1'b1;
  logic          iStart = 1'b0;
  logic          iValid = 1'b0;
  logic [31:0]   iData = '0;
  logic          iAck = 1'b0;
  logic          oReady;
  logic [6:0]    oCount;
  logic          oValid;
  logic [2047:0] oData;
  logic          oBusy;

  int nChecks = 0;
  int nErrors = 0;

  mod_word_collector2048 dut (
    .iClk(iClk), .iRst(iRst), .iStart(iStart), .iValid(iValid), .iData(iData),
    .oReady(oReady), .oCount(oCount), .oValid(oValid), .iAck(iAck),
    .oData(oData), .oBusy(oBusy)
  );

  always #5 iClk = ~iClk;

  function automatic logic [2047:0] expOperand(input int base);
    logic [2047:0] v;
    v = '0;
    for (int k = 0; k < 64; k++) v[k*32 +: 32] = 32'(base + k);
    return v;
  endfunction

  function automatic int firstDiff(input logic [2047:0] a, input logic [2047:0] b);
    for (int k = 0; k < 64; k++) if (a[k*32 +: 32] !== b[k*32 +: 32]) return k;
    return -1;
  endfunction

  // Called and returns at a negedge; drives words until n accepts or budget runs out
  task automatic sendWords(input int base, input int n, input bit toggle, output bit ok);
    int idx = 0;
    int cyc = 0;
    bit ph = 1'b0;
    while (idx < n && cyc < 400) begin
      iValid = toggle ? ph : 1'b1;
      iData  = 32'(base + idx);
      if (iValid && oReady) idx++;
      ph = !ph;
      cyc++;
      @(negedge iClk);
    end
    iValid = 1'b0;
    ok = (idx == n);
  endtask

  task automatic pulseStart();
    iStart = 1'b1;
    @(negedge iClk);
    iStart = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    nChecks++;
    if ({oReady, oValid, oBusy} !== 3'b000 || oCount !== 7'd0 || oData !== '0) begin
      nErrors++;
      $display("FAIL reset: rdy/vld/busy=%b cnt=%0d data_nonzero=%b, required 000 0 0",
               {oReady, oValid, oBusy}, oCount, |oData);
    end
    @(negedge iClk);
    iRst = 1'b0;
    iValid = 1'b1;
    iAck = 1'b1;
    @(negedge iClk);
    nChecks++;
    if (oBusy !== 1'b0 || oCount !== 7'd0) begin
      nErrors++;
      $display("FAIL idle_ignore: busy=%b cnt=%0d, required 0 0", oBusy, oCount);
    end
    iValid = 1'b0;
    iAck = 1'b0;
  endtask

  task automatic test_back_to_back();
    bit ok;
    int d;
    pulseStart();
    nChecks++;
    if (oReady !== 1'b1 || oCount !== 7'd0 || oBusy !== 1'b1) begin
      nErrors++;
      $display("FAIL start_latency: rdy=%b cnt=%0d busy=%b, required 1 0 1", oReady, oCount, oBusy);
    end
    sendWords(0, 64, 1'b0, ok);
    nChecks++;
    if (!ok) begin
      nErrors++;
      $display("FAIL b2b_timeout: accepts did not reach 64");
    end
    nChecks++;
    if (oValid !== 1'b1 || oReady !== 1'b0 || oCount !== 7'd64) begin
      nErrors++;
      $display("FAIL b2b_full: vld=%b rdy=%b cnt=%0d, required 1 0 64", oValid, oReady, oCount);
    end
    nChecks++;
    if (oData[31:0] !== 32'd0 || oData[2047:2016] !== 32'd63) begin
      nErrors++;
      $display("FAIL b2b_ends: low=%h high=%h, required 0 3f", oData[31:0], oData[2047:2016]);
    end
    nChecks++;
    d = firstDiff(oData, expOperand(0));
    if (d >= 0) begin
      nErrors++;
      $display("FAIL b2b_data: word %0d is %h, required %h", d, oData[d*32 +: 32], 32'(d));
    end
  endtask

  task automatic test_hold_ack();
    logic [2047:0] snap;
    int bad = 0;
    snap = oData;
    for (int i = 0; i < 20; i++) begin
      @(negedge iClk);
      if (oData !== snap || oValid !== 1'b1) bad++;
    end
    nChecks++;
    if (bad != 0) begin
      nErrors++;
      $display("FAIL hold: %0d unstable cycles, required 0", bad);
    end
    iAck = 1'b1;
    @(negedge iClk);
    iAck = 1'b0;
    nChecks++;
    if (oValid !== 1'b0 || oBusy !== 1'b0 || oReady !== 1'b0 || oCount !== 7'd64) begin
      nErrors++;
      $display("FAIL ack: vld=%b busy=%b rdy=%b cnt=%0d, required 0 0 0 64", oValid, oBusy, oReady, oCount);
    end
    nChecks++;
    if (oData !== expOperand(0)) begin
      nErrors++;
      $display("FAIL ack_data: word0=%h word63=%h, required 0 3f", oData[31:0], oData[2047:2016]);
    end
  endtask

  task automatic test_gaps();
    bit ok;
    int d;
    pulseStart();
    sendWords(0, 64, 1'b1, ok);
    nChecks++;
    if (!ok) begin
      nErrors++;
      $display("FAIL gaps_timeout: accepts did not reach 64");
    end
    iValid = 1'b1;
    iData = 32'hBAD0BAD0;
    repeat (5) @(negedge iClk);
    iValid = 1'b0;
    nChecks++;
    if (oValid !== 1'b1 || oCount !== 7'd64) begin
      nErrors++;
      $display("FAIL gaps_full: vld=%b cnt=%0d, required 1 64", oValid, oCount);
    end
    nChecks++;
    d = firstDiff(oData, expOperand(0));
    if (d >= 0) begin
      nErrors++;
      $display("FAIL gaps_data: word %0d is %h, required %h", d, oData[d*32 +: 32], 32'(d));
    end
    iAck = 1'b1;
    @(negedge iClk);
    iAck = 1'b0;
  endtask

  task automatic test_abort();
    bit ok;
    int d;
    pulseStart();
    sendWords(500, 10, 1'b0, ok);
    nChecks++;
    if (oCount !== 7'd10) begin
      nErrors++;
      $display("FAIL abort_pre: cnt=%0d, required 10", oCount);
    end
    iStart = 1'b1;
    iValid = 1'b1;
    iData = 32'hDEADBEEF;
    @(negedge iClk);
    iStart = 1'b0;
    iValid = 1'b0;
    nChecks++;
    if (oCount !== 7'd0 || oData !== '0 || oReady !== 1'b1) begin
      nErrors++;
      $display("FAIL abort: cnt=%0d data_nonzero=%b rdy=%b, required 0 0 1", oCount, |oData, oReady);
    end
    sendWords(100, 64, 1'b0, ok);
    nChecks++;
    if (!ok || oValid !== 1'b1 || oData[31:0] !== 32'd100) begin
      nErrors++;
      $display("FAIL abort_refill: ok=%b vld=%b word0=%h, required 1 1 64", ok, oValid, oData[31:0]);
    end
    nChecks++;
    d = firstDiff(oData, expOperand(100));
    if (d >= 0) begin
      nErrors++;
      $display("FAIL abort_data: word %0d is %h, required %h", d, oData[d*32 +: 32], 32'(100 + d));
    end
  endtask

  task automatic test_start_ack_full();
    iStart = 1'b1;
    iAck = 1'b1;
    @(negedge iClk);
    iStart = 1'b0;
    iAck = 1'b0;
    nChecks++;
    if (oReady !== 1'b1 || oValid !== 1'b0 || oCount !== 7'd0 || oBusy !== 1'b1 || oData !== '0) begin
      nErrors++;
      $display("FAIL start_ack: rdy=%b vld=%b cnt=%0d busy=%b data_nonzero=%b, required 1 0 0 1 0",
               oReady, oValid, oCount, oBusy, |oData);
    end
  endtask

  task automatic test_async_reset();
    bit ok;
    sendWords(7, 30, 1'b0, ok);
    nChecks++;
    if (oCount !== 7'd30) begin
      nErrors++;
      $display("FAIL rst_pre: cnt=%0d, required 30", oCount);
    end
    #2 iRst = 1'b1;
    #1;
    nChecks++;
    if ({oReady, oValid, oBusy} !== 3'b000 || oCount !== 7'd0 || oData !== '0) begin
      nErrors++;
      $display("FAIL async_rst: rdy/vld/busy=%b cnt=%0d data_nonzero=%b, required 000 0 0",
               {oReady, oValid, oBusy}, oCount, |oData);
    end
    #3 iRst = 1'b0;
    @(negedge iClk);
    iValid = 1'b1;
    iData = 32'h12345678;
    repeat (3) @(negedge iClk);
    iValid = 1'b0;
    nChecks++;
    if (oCount !== 7'd0 || oBusy !== 1'b0 || oReady !== 1'b0) begin
      nErrors++;
      $display("FAIL post_rst: cnt=%0d busy=%b rdy=%b, required 0 0 0", oCount, oBusy, oReady);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_hold_ack();
    test_gaps();
    test_abort();
    test_start_ack_full();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
